// File: rtl/datapath_ctrl.sv
// Instruction register, decoder and multi-cycle Moore sequencer for the 16-bit regfile/ALU datapath.
// Optional macro DATAPATH_CTRL_INSN_COUNT_EN adds the insn_count output (completed-instruction counter).
module datapath_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in,
  input  logic        load_ir,
  input  logic        s,
  input  logic        mem_ready,
  output logic        w,
  output logic        halted,
  output logic        illegal,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        load_addr,
  output logic        mem_rd,
`ifdef DATAPATH_CTRL_INSN_COUNT_EN
  output logic [15:0] insn_count,
`endif
  output logic        mem_wr
);

  typedef enum logic [3:0] {
    S_WAIT, S_DECODE, S_WIMM, S_GETA, S_GETB, S_ALU, S_WREG,
    S_ADDR, S_LADDR, S_MEMRD, S_LDWB, S_MEMWR, S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_ir;

  logic [2:0] w_opcode;
  logic [1:0] w_op;
  logic [2:0] w_rn;
  logic [2:0] w_rd;
  logic [1:0] w_sh;
  logic [2:0] w_rm;
  logic       w_isMovImm;
  logic       w_isMovReg;
  logic       w_isAlu;
  logic       w_isCmp;
  logic       w_isLdr;
  logic       w_isStr;
  logic       w_isHalt;

  assign w_opcode = r_ir[15:13];
  assign w_op     = r_ir[12:11];
  assign w_rn     = r_ir[10:8];
  assign w_rd     = r_ir[7:5];
  assign w_sh     = r_ir[4:3];
  assign w_rm     = r_ir[2:0];

  assign w_isMovImm = (w_opcode == 3'b110) && (w_op == 2'b10);
  assign w_isMovReg = (w_opcode == 3'b110) && (w_op == 2'b00);
  assign w_isAlu    = (w_opcode == 3'b101);
  assign w_isCmp    = w_isAlu && (w_op == 2'b01);
  assign w_isLdr    = (w_opcode == 3'b011) && (w_op == 2'b00);
  assign w_isStr    = (w_opcode == 3'b100) && (w_op == 2'b00);
  assign w_isHalt   = (w_opcode == 3'b111);

  assign sximm8 = {{8{r_ir[7]}}, r_ir[7:0]};
  assign sximm5 = {{11{r_ir[4]}}, r_ir[4:0]};
  assign shift  = (w_isAlu || w_isMovReg) ? w_sh : 2'b00;

  // IR only accepts a new word while idle, so a running sequence always sees a stable instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_ir <= 16'h0000;
    else if (load_ir && (r_state == S_WAIT))
      r_ir <= in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= S_WAIT;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w         = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    readnum   = 3'd0;
    writenum  = 3'd0;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    vsel      = 2'b00;
    ALUop     = 2'b00;
    load_addr = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    case (r_state)
      S_WAIT: begin
        w = 1'b1;
        if (s) w_next = S_DECODE;
      end
      S_DECODE: begin
        if (w_isMovImm)                      w_next = S_WIMM;
        else if (w_isMovReg)                 w_next = S_GETB;
        else if (w_isAlu || w_isLdr || w_isStr) w_next = S_GETA;
        else if (w_isHalt)                   w_next = S_HALT;
        else begin
          illegal = 1'b1;
          w_next  = S_WAIT;
        end
      end
      S_WIMM: begin
        writenum = w_rn;
        vsel     = 2'b01;
        write    = 1'b1;
        w_next   = S_WAIT;
      end
      S_GETA: begin
        readnum = w_rn;
        loada   = 1'b1;
        w_next  = w_isAlu ? S_GETB : S_ADDR;
      end
      // STR reuses GETB/ALU to route the store data (Rd) through to C
      S_GETB: begin
        readnum = w_isStr ? w_rd : w_rm;
        loadb   = 1'b1;
        w_next  = S_ALU;
      end
      S_ALU: begin
        asel  = ~w_isAlu;
        ALUop = w_isAlu ? w_op : 2'b00;
        loadc = 1'b1;
        loads = w_isCmp;
        if (w_isStr)      w_next = S_MEMWR;
        else if (w_isCmp) w_next = S_WAIT;
        else              w_next = S_WREG;
      end
      S_WREG: begin
        writenum = w_rd;
        vsel     = 2'b11;
        write    = 1'b1;
        w_next   = S_WAIT;
      end
      S_ADDR: begin
        bsel   = 1'b1;
        loadc  = 1'b1;
        w_next = S_LADDR;
      end
      S_LADDR: begin
        load_addr = 1'b1;
        w_next    = w_isStr ? S_GETB : S_MEMRD;
      end
      S_MEMRD: begin
        mem_rd = 1'b1;
        if (mem_ready) w_next = S_LDWB;
      end
      S_LDWB: begin
        writenum = w_rd;
        vsel     = 2'b00;
        write    = 1'b1;
        w_next   = S_WAIT;
      end
      S_MEMWR: begin
        mem_wr = 1'b1;
        if (mem_ready) w_next = S_WAIT;
      end
      S_HALT: begin
        halted = 1'b1;
        w_next = S_HALT;
      end
      default: w_next = S_WAIT;
    endcase
  end

`ifdef DATAPATH_CTRL_INSN_COUNT_EN
  // Only an illegal opcode returns to WAIT straight from DECODE, so every other return is a completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      insn_count <= 16'h0000;
    else if ((w_next == S_WAIT) && (r_state != S_WAIT) && (r_state != S_DECODE))
      insn_count <= insn_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_datapath_ctrl.sv
// Self-checking bench for datapath_ctrl: per-instruction expected cycle lists built from the ISA rules,
// checked every cycle, plus directed latency/count checks with hand-computed values.
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] insnIn;
  logic        load_ir, s, mem_ready;
  logic        w, halted, illegal;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8, sximm5;
  logic        load_addr, mem_rd, mem_wr;
`ifdef DATAPATH_CTRL_INSN_COUNT_EN
  logic [15:0] insnCount;
`endif

  datapath_ctrl dut (
`ifdef DATAPATH_CTRL_INSN_COUNT_EN
    .insn_count(insnCount),
`endif
    .clk(clk), .reset_n(reset_n), .in(insnIn), .load_ir(load_ir), .s(s),
    .mem_ready(mem_ready), .w(w), .halted(halted), .illegal(illegal),
    .readnum(readnum), .writenum(writenum), .write(write), .loada(loada),
    .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
    .vsel(vsel), .shift(shift), .ALUop(ALUop), .sximm8(sximm8), .sximm5(sximm5),
    .load_addr(load_addr), .mem_rd(mem_rd), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       w, halted, illegal, write, loada, loadb, loadc, loads;
    logic       asel, bsel, loadAddr, memRd, memWr, mr;
    logic [2:0] readnum, writenum;
    logic [1:0] vsel, aluop;
  } exp_t;

  exp_t        expQ[$];
  exp_t        expCur;
  bit          expValid = 1'b0;
  logic [15:0] mIR = 16'h0000;
  logic [15:0] mCount = 16'h0000;
  int          checks = 0;
  int          errors = 0;
  int          edgeCnt, latVal;
  bit          latArm = 1'b0;
  int          writeCnt = 0, loadsCnt = 0, memRdCnt = 0, memWrCnt = 0, loadAddrCnt = 0, illegalCnt = 0;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t blank();
    exp_t e;
    e.w = 0; e.halted = 0; e.illegal = 0; e.write = 0; e.loada = 0; e.loadb = 0;
    e.loadc = 0; e.loads = 0; e.asel = 0; e.bsel = 0; e.loadAddr = 0; e.memRd = 0;
    e.memWr = 0; e.readnum = 0; e.writenum = 0; e.vsel = 0; e.aluop = 0;
    e.mr = 1'($urandom);
    return e;
  endfunction

  function automatic exp_t idle();
    exp_t e = blank();
    e.w = 1'b1;
    return e;
  endfunction

  function automatic bit isLegal(input logic [15:0] ir);
    case (ir[15:13])
      3'b110:         return (ir[12:11] == 2'b10) || (ir[12:11] == 2'b00);
      3'b101, 3'b111: return 1'b1;
      3'b011, 3'b100: return ir[12:11] == 2'b00;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] expShift(input logic [15:0] ir);
    if (ir[15:13] == 3'b101 || ir[15:11] == 5'b11000) return ir[4:3];
    return 2'b00;
  endfunction

  // Expected per-cycle outputs of one instruction, from DECODE up to the cycle before WAIT
  task automatic buildSeq(input logic [15:0] ir, input int waits, output bit counted);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op;
    exp_t e;
    opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8]; rd = ir[7:5]; rm = ir[2:0];
    expQ.delete();
    e = blank(); e.illegal = !isLegal(ir); expQ.push_back(e);
    counted = isLegal(ir) && (opc != 3'b111);
    if (!isLegal(ir)) return;
    if (opc == 3'b111) begin
      repeat (8) begin e = blank(); e.halted = 1; expQ.push_back(e); end
      return;
    end
    if (opc == 3'b110 && op == 2'b10) begin
      e = blank(); e.writenum = rn; e.vsel = 2'b01; e.write = 1; expQ.push_back(e);
      return;
    end
    if (opc != 3'b110) begin
      e = blank(); e.readnum = rn; e.loada = 1; expQ.push_back(e);
    end
    if (opc == 3'b011 || opc == 3'b100) begin
      e = blank(); e.bsel = 1; e.loadc = 1; expQ.push_back(e);
      e = blank(); e.loadAddr = 1; expQ.push_back(e);
    end
    if (opc == 3'b011) begin
      for (int k = 0; k <= waits; k++) begin
        e = blank(); e.memRd = 1; e.mr = (k == waits); expQ.push_back(e);
      end
      e = blank(); e.writenum = rd; e.vsel = 2'b00; e.write = 1; expQ.push_back(e);
      return;
    end
    e = blank(); e.readnum = (opc == 3'b100) ? rd : rm; e.loadb = 1; expQ.push_back(e);
    e = blank(); e.asel = (opc != 3'b101); e.aluop = (opc == 3'b101) ? op : 2'b00;
    e.loadc = 1; e.loads = (opc == 3'b101) && (op == 2'b01); expQ.push_back(e);
    if (opc == 3'b100) begin
      for (int k = 0; k <= waits; k++) begin
        e = blank(); e.memWr = 1; e.mr = (k == waits); expQ.push_back(e);
      end
      return;
    end
    if (!(opc == 3'b101 && op == 2'b01)) begin
      e = blank(); e.writenum = rd; e.vsel = 2'b11; e.write = 1; expQ.push_back(e);
    end
  endtask

  // One cycle: publish the expectation for this cycle, drive inputs for the coming edge
  task automatic applyStimulus(input exp_t e, input logic ld, input logic st, input logic [15:0] din);
    expCur = e; expValid = 1'b1;
    insnIn = din; load_ir = ld; s = st; mem_ready = e.mr;
    @(posedge clk); #1;
    if (ld && e.w && reset_n) mIR = din;
    edgeCnt++;
    if (latArm && w === 1'b1) begin latVal = edgeCnt; latArm = 1'b0; end
  endtask

  task automatic doReset(input int cycles);
    expValid = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("rstMemRd", 16'(mem_rd), 16'd0);
    checkOutput("rstMemWr", 16'(mem_wr), 16'd0);
    checkOutput("rstW", 16'(w), 16'd1);
    checkOutput("rstHalted", 16'(halted), 16'd0);
    checkOutput("rstIllegal", 16'(illegal), 16'd0);
    checkOutput("rstIrImm8", sximm8, 16'h0000);
    mIR = 16'h0000; mCount = 16'h0000; latArm = 1'b0;
    repeat (cycles) applyStimulus(idle(), 1'($urandom), 1'($urandom), 16'($urandom));
    reset_n = 1'b1;
  endtask

  task automatic runInsn(input logic [15:0] instr, input bit doLoad, input int waits,
                         input int abortAt, output int lat);
    bit counted;
    buildSeq(doLoad ? instr : mIR, waits, counted);
    edgeCnt = 0; latVal = 0; latArm = 1'b1;
    applyStimulus(idle(), doLoad, 1'b1, doLoad ? instr : 16'($urandom));
    for (int i = 0; i < expQ.size(); i++) begin
      if (i == abortAt) begin
        checkOutput("preRstMemRd", 16'(mem_rd), 16'd1);
        doReset(2);
        lat = 0;
        return;
      end
      applyStimulus(expQ[i], 1'($urandom), 1'($urandom), 16'($urandom));
    end
    if (counted) mCount = mCount + 16'd1;
    latArm = 1'b0;
    lat = latVal;
  endtask

  function automatic logic [15:0] genInsn();
    logic [15:0] r = 16'($urandom);
    case ($urandom_range(5, 0))
      0: r[15:11] = 5'b11010;
      1: r[15:11] = 5'b11000;
      2: r[15:13] = 3'b101;
      3: r[15:11] = 5'b01100;
      4: r[15:11] = 5'b10000;
      default: if (r[15:13] == 3'b111) r[15:13] = 3'b000;
    endcase
    return r;
  endfunction

  // Compare process: every cycle with a published expectation
  always @(negedge clk) begin
    if (expValid) begin
      checkOutput("w", 16'(w), 16'(expCur.w));
      checkOutput("halted", 16'(halted), 16'(expCur.halted));
      checkOutput("illegal", 16'(illegal), 16'(expCur.illegal));
      checkOutput("readnum", 16'(readnum), 16'(expCur.readnum));
      checkOutput("writenum", 16'(writenum), 16'(expCur.writenum));
      checkOutput("write", 16'(write), 16'(expCur.write));
      checkOutput("loada", 16'(loada), 16'(expCur.loada));
      checkOutput("loadb", 16'(loadb), 16'(expCur.loadb));
      checkOutput("loadc", 16'(loadc), 16'(expCur.loadc));
      checkOutput("loads", 16'(loads), 16'(expCur.loads));
      checkOutput("asel", 16'(asel), 16'(expCur.asel));
      checkOutput("bsel", 16'(bsel), 16'(expCur.bsel));
      checkOutput("vsel", 16'(vsel), 16'(expCur.vsel));
      checkOutput("ALUop", 16'(ALUop), 16'(expCur.aluop));
      checkOutput("load_addr", 16'(load_addr), 16'(expCur.loadAddr));
      checkOutput("mem_rd", 16'(mem_rd), 16'(expCur.memRd));
      checkOutput("mem_wr", 16'(mem_wr), 16'(expCur.memWr));
      checkOutput("shift", 16'(shift), 16'(expShift(mIR)));
      checkOutput("sximm8", sximm8, {{8{mIR[7]}}, mIR[7:0]});
      checkOutput("sximm5", sximm5, {{11{mIR[4]}}, mIR[4:0]});
`ifdef DATAPATH_CTRL_INSN_COUNT_EN
      checkOutput("insn_count", insnCount, mCount);
`endif
      if (write)     writeCnt++;
      if (loads)     loadsCnt++;
      if (mem_rd)    memRdCnt++;
      if (mem_wr)    memWrCnt++;
      if (load_addr) loadAddrCnt++;
      if (illegal)   illegalCnt++;
    end
  end

  initial begin
    int lat, c0, c1, c2;
    reset_n = 1'b1; insnIn = 16'h0; load_ir = 0; s = 0; mem_ready = 0;
    #2;
    doReset(2);

    // Reset during a waiting LDR, then execute the cleared IR (opcode 000 is illegal)
    runInsn(16'h6061, 1'b1, 3, 4, lat);
    c0 = illegalCnt;
    runInsn(16'h0000, 1'b0, 0, -1, lat);
    checkOutput("illegalLat", 16'(lat), 16'd2);
    checkOutput("illegalOnce", 16'(illegalCnt - c0), 16'd1);

    runInsn(16'hD007, 1'b1, 0, -1, lat);
    checkOutput("movImmLat", 16'(lat), 16'd3);
    checkOutput("movImmSximm8", sximm8, 16'h0007);

    c0 = writeCnt; c1 = loadsCnt;
    runInsn(16'hA041, 1'b1, 0, -1, lat);
    checkOutput("addLat", 16'(lat), 16'd6);
    checkOutput("addWrites", 16'(writeCnt - c0), 16'd1);
    checkOutput("addNoLoads", 16'(loadsCnt - c1), 16'd0);

    c0 = writeCnt; c1 = loadsCnt;
    runInsn(16'hA801, 1'b1, 0, -1, lat);
    checkOutput("cmpLat", 16'(lat), 16'd5);
    checkOutput("cmpNoWrite", 16'(writeCnt - c0), 16'd0);
    checkOutput("cmpLoads", 16'(loadsCnt - c1), 16'd1);

    c0 = memRdCnt; c1 = loadAddrCnt;
    runInsn(16'h6061, 1'b1, 3, -1, lat);
    checkOutput("ldrLat", 16'(lat), 16'd10);
    checkOutput("ldrMemRdCycles", 16'(memRdCnt - c0), 16'd4);
    checkOutput("ldrLoadAddr", 16'(loadAddrCnt - c1), 16'd1);
    checkOutput("ldrSximm5", sximm5, 16'h0001);

    c0 = memWrCnt; c2 = memRdCnt;
    runInsn(16'h8061, 1'b1, 2, -1, lat);
    checkOutput("strLat", 16'(lat), 16'd10);
    checkOutput("strMemWrCycles", 16'(memWrCnt - c0), 16'd3);
    checkOutput("strNoMemRd", 16'(memRdCnt - c2), 16'd0);
    checkOutput("strIrKept", r16(sximm5), 16'h0001);

    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(2, 0)) applyStimulus(idle(), 1'($urandom), 1'b0, genInsn());
      runInsn(genInsn(), ($urandom_range(3, 0) != 0), $urandom_range(3, 0), -1, lat);
    end

    runInsn(16'hE000, 1'b1, 0, -1, lat);
    checkOutput("haltNoReady", 16'(lat), 16'd0);
    checkOutput("haltHeld", 16'(halted), 16'd1);
    checkOutput("haltW", 16'(w), 16'd0);
    doReset(2);
    runInsn(16'hD1FF, 1'b1, 0, -1, lat);
    checkOutput("postHaltLat", 16'(lat), 16'd3);
    checkOutput("postHaltImm8", sximm8, 16'hFFFF);
    applyStimulus(idle(), 1'b0, 1'b0, 16'h0);
    expValid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [15:0] r16(input logic [15:0] v);
    return v;
  endfunction

endmodule
